// File: rtl/mcm_fc_pipe.sv
// mcm_fc_pipe: multiple-constant multiplier for the VVC intra 4-tap fC
// interpolation filter. Each lane's unsigned sample is multiplied by the four
// coefficients of the row selected by frac. The products come from shared
// shift/add/subtract networks, so the design contains no generic multipliers.
// A valid/ready output register gives a latency of 1 cycle.
// Optional feature: define MCM_FC_PIPE_INREG_EN to add an input register
// stage (x, frac, valid) ahead of the products. This raises the latency to 2.
module mcm_fc_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int LANES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 frac,
  input  logic [LANES*IN_W-1:0]      x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*LANES*OUT_W-1:0]   y
);

  // Largest product is 64*x, so IN_W+7 signed bits always hold it exactly.
  if (OUT_W < IN_W + 7 || LANES < 1) begin : g_param_check
    $error("mcm_fc_pipe: requires OUT_W >= IN_W+7 and LANES >= 1");
  end

  // Four fC taps for one sample, packed {t3, t2, t1, t0}. Every odd multiple
  // is formed once from shifts and adds. Negative taps are the two's
  // complement of the magnitude, and the result is exact in OUT_W bits.
  function automatic logic [4*OUT_W-1:0] fc_lane(input logic [IN_W-1:0] xs,
                                                 input logic [4:0] f);
    logic [OUT_W-1:0] xe;
    logic [OUT_W-1:0] p1, p2, p3, p4, p5, p6, p7, p10, p12, p14, p15, p16;
    logic [OUT_W-1:0] p18, p20, p24, p28, p29, p30, p33, p36, p39, p42, p44;
    logic [OUT_W-1:0] p46, p49, p52, p53, p54, p55, p56, p57, p58, p60, p62;
    logic [OUT_W-1:0] p63, p64;
    logic [OUT_W-1:0] t0, t1, t2, t3;
    xe  = OUT_W'(xs);
    p1  = xe;
    p2  = xe << 1;
    p3  = (xe << 1) + xe;
    p4  = xe << 2;
    p5  = (xe << 2) + xe;
    p6  = (xe << 2) + (xe << 1);
    p7  = (xe << 3) - xe;
    p10 = (xe << 3) + (xe << 1);
    p12 = (xe << 3) + (xe << 2);
    p14 = (xe << 4) - (xe << 1);
    p15 = (xe << 4) - xe;
    p16 = xe << 4;
    p18 = (xe << 4) + (xe << 1);
    p20 = (xe << 4) + (xe << 2);
    p24 = (xe << 4) + (xe << 3);
    p28 = (xe << 5) - (xe << 2);
    p29 = (xe << 5) - (xe << 1) - xe;
    p30 = (xe << 5) - (xe << 1);
    p33 = (xe << 5) + xe;
    p36 = (xe << 5) + (xe << 2);
    p39 = (xe << 5) + (xe << 3) - xe;
    p42 = (xe << 5) + (xe << 3) + (xe << 1);
    p44 = (xe << 5) + (xe << 3) + (xe << 2);
    p46 = (xe << 5) + (xe << 4) - (xe << 1);
    p49 = (xe << 5) + (xe << 4) + xe;
    p52 = (xe << 6) - (xe << 3) - (xe << 2);
    p53 = (xe << 6) - (xe << 3) - (xe << 1) - xe;
    p54 = (xe << 6) - (xe << 3) - (xe << 1);
    p55 = (xe << 6) - (xe << 3) - xe;
    p56 = (xe << 6) - (xe << 3);
    p57 = (xe << 6) - (xe << 3) + xe;
    p58 = (xe << 6) - (xe << 2) - (xe << 1);
    p60 = (xe << 6) - (xe << 2);
    p62 = (xe << 6) - (xe << 1);
    p63 = (xe << 6) - xe;
    p64 = xe << 6;
    t0 = '0;
    t1 = '0;
    t2 = '0;
    t3 = '0;
    unique case (f)
      5'd0:  begin t0 = '0;   t1 = p64; t2 = '0;  t3 = '0;   end
      5'd1:  begin t0 = -p1;  t1 = p63; t2 = p2;  t3 = '0;   end
      5'd2:  begin t0 = -p2;  t1 = p62; t2 = p4;  t3 = '0;   end
      5'd3:  begin t0 = -p2;  t1 = p60; t2 = p7;  t3 = -p1;  end
      5'd4:  begin t0 = -p2;  t1 = p58; t2 = p10; t3 = -p2;  end
      5'd5:  begin t0 = -p3;  t1 = p57; t2 = p12; t3 = -p2;  end
      5'd6:  begin t0 = -p4;  t1 = p56; t2 = p14; t3 = -p2;  end
      5'd7:  begin t0 = -p4;  t1 = p55; t2 = p15; t3 = -p2;  end
      5'd8:  begin t0 = -p4;  t1 = p54; t2 = p16; t3 = -p2;  end
      5'd9:  begin t0 = -p5;  t1 = p53; t2 = p18; t3 = -p2;  end
      5'd10: begin t0 = -p6;  t1 = p52; t2 = p20; t3 = -p2;  end
      5'd11: begin t0 = -p6;  t1 = p49; t2 = p24; t3 = -p3;  end
      5'd12: begin t0 = -p6;  t1 = p46; t2 = p28; t3 = -p4;  end
      5'd13: begin t0 = -p5;  t1 = p44; t2 = p29; t3 = -p4;  end
      5'd14: begin t0 = -p4;  t1 = p42; t2 = p30; t3 = -p4;  end
      5'd15: begin t0 = -p4;  t1 = p39; t2 = p33; t3 = -p4;  end
      5'd16: begin t0 = -p4;  t1 = p36; t2 = p36; t3 = -p4;  end
      5'd17: begin t0 = -p4;  t1 = p33; t2 = p39; t3 = -p4;  end
      5'd18: begin t0 = -p4;  t1 = p30; t2 = p42; t3 = -p4;  end
      5'd19: begin t0 = -p4;  t1 = p29; t2 = p44; t3 = -p5;  end
      5'd20: begin t0 = -p4;  t1 = p28; t2 = p46; t3 = -p6;  end
      5'd21: begin t0 = -p3;  t1 = p24; t2 = p49; t3 = -p6;  end
      5'd22: begin t0 = -p2;  t1 = p20; t2 = p52; t3 = -p6;  end
      5'd23: begin t0 = -p2;  t1 = p18; t2 = p53; t3 = -p5;  end
      5'd24: begin t0 = -p2;  t1 = p16; t2 = p54; t3 = -p4;  end
      5'd25: begin t0 = -p2;  t1 = p15; t2 = p55; t3 = -p4;  end
      5'd26: begin t0 = -p2;  t1 = p14; t2 = p56; t3 = -p4;  end
      5'd27: begin t0 = -p2;  t1 = p12; t2 = p57; t3 = -p3;  end
      5'd28: begin t0 = -p2;  t1 = p10; t2 = p58; t3 = -p2;  end
      5'd29: begin t0 = -p1;  t1 = p7;  t2 = p60; t3 = -p2;  end
      5'd30: begin t0 = '0;   t1 = p4;  t2 = p62; t3 = -p2;  end
      5'd31: begin t0 = '0;   t1 = p2;  t2 = p63; t3 = -p1;  end
      default: begin t0 = '0; t1 = '0; t2 = '0; t3 = '0; end
    endcase
    return {t3, t2, t1, t0};
  endfunction

  logic [LANES*IN_W-1:0]    src_x;
  logic [4:0]               src_frac;
  logic                     out_load;
  logic [4*LANES*OUT_W-1:0] prod;

  // Product array for every lane. All lanes share the selected row.
  always_comb begin
    prod = '0;
    for (int k = 0; k < LANES; k++) begin
      prod[k*4*OUT_W +: 4*OUT_W] = fc_lane(src_x[k*IN_W +: IN_W], src_frac);
    end
  end

`ifdef MCM_FC_PIPE_INREG_EN
  logic                  s1_valid;
  logic [LANES*IN_W-1:0] s1_x;
  logic [4:0]            s1_frac;
  logic                  s2_ready;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign src_x    = s1_x;
  assign src_frac = s1_frac;
  assign out_load = s1_valid && s2_ready;

  // Input stage: capture a bundle on handshake, empty it when it moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_frac  <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_x     <= x;
      s1_frac  <= frac;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
  assign src_x    = x;
  assign src_frac = frac;
  assign out_load = in_valid && in_ready;
`endif

  // Output stage: load new products, or drop valid after a plain transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (out_load) begin
      out_valid <= 1'b1;
      y         <= prod;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mcm_fc_pipe.sv
// tb_mcm_fc_pipe: self-checking bench for mcm_fc_pipe (IN_W=8, OUT_W=16,
// LANES=2). A negedge monitor records accepted bundles, turned into expected
// products by an arithmetic reference model, and completed output transfers.
// Each scenario task compares the two streams and its own point checks.
module tb_mcm_fc_pipe;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int LANES = 2;
  localparam int XW    = LANES*IN_W;
  localparam int YW    = 4*LANES*OUT_W;
`ifdef MCM_FC_PIPE_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [YW-1:0] yv_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    frac;
  logic [XW-1:0] x;
  logic          out_valid;
  logic          out_ready;
  yv_t           y;

  int  n_vec  = 0;
  int  n_fail = 0;
  yv_t exp_q[$];
  yv_t obs_q[$];

  int fc_tab [32][4] = '{
    '{ 0, 64,  0,  0}, '{-1, 63,  2,  0}, '{-2, 62,  4,  0}, '{-2, 60,  7, -1},
    '{-2, 58, 10, -2}, '{-3, 57, 12, -2}, '{-4, 56, 14, -2}, '{-4, 55, 15, -2},
    '{-4, 54, 16, -2}, '{-5, 53, 18, -2}, '{-6, 52, 20, -2}, '{-6, 49, 24, -3},
    '{-6, 46, 28, -4}, '{-5, 44, 29, -4}, '{-4, 42, 30, -4}, '{-4, 39, 33, -4},
    '{-4, 36, 36, -4}, '{-4, 33, 39, -4}, '{-4, 30, 42, -4}, '{-4, 29, 44, -5},
    '{-4, 28, 46, -6}, '{-3, 24, 49, -6}, '{-2, 20, 52, -6}, '{-2, 18, 53, -5},
    '{-2, 16, 54, -4}, '{-2, 15, 55, -4}, '{-2, 14, 56, -4}, '{-2, 12, 57, -3},
    '{-2, 10, 58, -2}, '{-1,  7, 60, -2}, '{ 0,  4, 62, -2}, '{ 0,  2, 63, -1}
  };

  mcm_fc_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .frac(frac), .x(x), .out_valid(out_valid), .out_ready(out_ready), .y(y)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer products, truncated to OUT_W bits.
  function automatic yv_t model(input logic [XW-1:0] xv, input logic [4:0] f);
    yv_t r;
    int  p;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int t = 0; t < 4; t++) begin
        p = int'(xv[k*IN_W +: IN_W]) * fc_tab[f][t];
        r[(k*4+t)*OUT_W +: OUT_W] = p[OUT_W-1:0];
      end
    end
    return r;
  endfunction

  function automatic int tap(input yv_t v, input int k, input int t);
    logic signed [OUT_W-1:0] s;
    s = v[(k*4+t)*OUT_W +: OUT_W];
    return int'(s);
  endfunction

  // Handshake monitor, sampled mid-cycle for the upcoming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      obs_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(x, frac));
      if (out_valid && out_ready) obs_q.push_back(y);
    end
  end

  task automatic test_reset;
    $display("[TB] test_reset");
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    x = XW'($urandom); frac = 5'($urandom);
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (y !== '0) begin n_fail++; $display("[TB] FAIL reset_y got %h want 0", y); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    n_vec++; if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL reset_no_output got %0d outputs want 0", obs_q.size()); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_idle_valid got %b want 0", out_valid); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_coeff;
    int want [4] = '{-1020, 9180, 9180, -1020};
    yv_t o, e;
    $display("[TB] test_coeff");
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; frac = 5'd16;
    x = {8'($urandom), 8'd255};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL coeff_latency_valid got %b want 1", out_valid); end
    for (int t = 0; t < 4; t++) begin
      n_vec++;
      if (tap(y, 0, t) !== want[t]) begin n_fail++; $display("[TB] FAIL coeff_tap%0d got %0d want %0d", t, tap(y, 0, t), want[t]); end
    end
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (obs_q.size() !== 1 || exp_q.size() !== 1) begin n_fail++; $display("[TB] FAIL coeff_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (o !== e) begin n_fail++; $display("[TB] FAIL coeff_model got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_lanes;
    int want0 [4] = '{-200, 12600, 400, 0};
    int want1 [4] = '{-10, 630, 20, 0};
    $display("[TB] test_lanes");
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1; frac = 5'd1;
    x = {8'd10, 8'd200};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL lanes_valid got %b want 1", out_valid); end
    for (int t = 0; t < 4; t++) begin
      n_vec++; if (tap(y, 0, t) !== want0[t]) begin n_fail++; $display("[TB] FAIL lane0_tap%0d got %0d want %0d", t, tap(y, 0, t), want0[t]); end
      n_vec++; if (tap(y, 1, t) !== want1[t]) begin n_fail++; $display("[TB] FAIL lane1_tap%0d got %0d want %0d", t, tap(y, 1, t), want1[t]); end
    end
    repeat (LAT + 3) @(posedge clk);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_edge_rows;
    yv_t o, e;
    int  row;
    $display("[TB] test_edge_rows");
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; frac = 5'(i); x = {8'd0, 8'd1};
      @(negedge clk);
      n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rows_in_ready row %0d got %b want 1", i, in_ready); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    n_vec++; if (obs_q.size() !== 32) begin n_fail++; $display("[TB] FAIL rows_count got %0d want 32", obs_q.size()); end
    row = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      for (int t = 0; t < 4; t++) begin
        n_vec++; if (tap(o, 0, t) !== fc_tab[row][t]) begin n_fail++; $display("[TB] FAIL row%0d_tap%0d got %0d want %0d", row, t, tap(o, 0, t), fc_tab[row][t]); end
      end
      n_vec++; if (o !== e) begin n_fail++; $display("[TB] FAIL row%0d_zero_lane got %h want %h", row, o, e); end
      row++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [XW-1:0] xs [3];
    logic [4:0]    fs [3];
    int            idx;
    logic          prev_stall;
    yv_t           prev_y, o, e;
    $display("[TB] test_back_to_back");
    for (int i = 0; i < 3; i++) begin xs[i] = XW'($urandom); fs[i] = 5'($urandom); end
    idx = 0; prev_stall = 1'b0; prev_y = '0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 4);
      if (idx < 3) begin in_valid = 1'b1; x = xs[idx]; frac = fs[idx]; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (prev_stall) begin
        n_vec++; if (out_valid !== 1'b1 || y !== prev_y) begin n_fail++; $display("[TB] FAIL stall_hold cyc %0d got %b/%h want 1/%h", cyc, out_valid, y, prev_y); end
      end
      if (cyc == 3) begin
        n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready got %b want 0", in_ready); end
      end
      prev_stall = out_valid && !out_ready;
      prev_y = y;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (idx !== 3) begin n_fail++; $display("[TB] FAIL b2b_accepted got %0d want 3", idx); end
    n_vec++; if (obs_q.size() !== 3 || exp_q.size() !== 3) begin n_fail++; $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (o !== e) begin n_fail++; $display("[TB] FAIL b2b_order got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random;
    logic prev_stall;
    yv_t  prev_y, o, e;
    $display("[TB] test_random");
    prev_stall = 1'b0; prev_y = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      x = XW'($urandom); frac = 5'($urandom);
      if (cyc % 50 == 0) x = '0;
      @(negedge clk);
      if (prev_stall) begin
        n_vec++; if (out_valid !== 1'b1 || y !== prev_y) begin n_fail++; $display("[TB] FAIL rand_stall cyc %0d got %b/%h want 1/%h", cyc, out_valid, y, prev_y); end
      end
      prev_stall = out_valid && !out_ready;
      prev_y = y;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("[TB] FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_vec++; if (o !== e) begin n_fail++; $display("[TB] FAIL rand_data got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid;
    $display("[TB] test_reset_mid");
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; x = XW'($urandom); frac = 5'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pending_valid got %b want 1", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b1; x = XW'($urandom); frac = 5'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid got %b want 0", out_valid); end
    n_vec++; if (y !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_y got %h want 0", y); end
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);
    n_vec++; if (obs_q.size() !== 0) begin n_fail++; $display("[TB] FAIL mid_reset_leak got %0d outputs want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; frac = '0; x = '0;
    test_reset;
    test_coeff;
    test_lanes;
    test_edge_rows;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
